// File: rtl/reg_bank_16x64_if.sv
// rtl/reg_bank_16x64_if.sv - write/read bus bundle for the 16x64 register bank
interface reg_bank_16x64_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);
  logic              regwen;
  logic [DATA_W-1:0] inA;
  logic [ADDR_W-1:0] selwreg;
  logic [1:0]        endwreg;
  logic [ADDR_W-1:0] seloutA;
  logic [ADDR_W-1:0] seloutB;
  logic              enrregA;
  logic              enrregB;
  logic              cnstA;
  logic              cnstB;
  logic [DATA_W-1:0] outA;
  logic [DATA_W-1:0] outB;

  modport master (
    output regwen, inA, selwreg, endwreg, seloutA, seloutB,
    output enrregA, enrregB, cnstA, cnstB,
    input  outA, outB
  );

  modport slave (
    input  regwen, inA, selwreg, endwreg, seloutA, seloutB,
    input  enrregA, enrregB, cnstA, cnstB,
    output outA, outB
  );
endinterface

// File: rtl/reg_bank_16x64.sv
// rtl/reg_bank_16x64.sv - 16x64 register file, one lane-masked write port, two registered read ports
// Lane-mode writes are enabled by defining REG_BANK_WRITE_MASK_EN; otherwise every write is whole-word.
module reg_bank_16x64 #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 2**ADDR_W
) (
  input logic               clock,
  input logic               reset,
  reg_bank_16x64_if.slave   bus
);
  localparam int HALF_W = DATA_W / 2;
  localparam int QTR_W  = DATA_W / 4;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] outa_q, outa_d;
  logic [DATA_W-1:0] outb_q, outb_d;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;

  assign wr_old = regs_q[bus.selwreg];

`ifdef REG_BANK_WRITE_MASK_EN
  always_comb begin
    wr_merged = bus.inA;
    case (bus.endwreg)
      2'b01:   wr_merged = {wr_old[DATA_W-1:HALF_W], bus.inA[HALF_W-1:0]};
      2'b10:   wr_merged = {bus.inA[DATA_W-1:HALF_W], wr_old[HALF_W-1:0]};
      2'b11:   wr_merged = {wr_old[DATA_W-1:QTR_W], bus.inA[QTR_W-1:0]};
      default: wr_merged = bus.inA;
    endcase
  end
`else
  logic endwreg_unused;
  logic [DATA_W-1:0] wr_old_unused;
  assign endwreg_unused = ^bus.endwreg;
  assign wr_old_unused  = wr_old;
  assign wr_merged      = bus.inA;
`endif

  // Write-through: a bypassing port sees the merged word landing this edge.
  always_comb begin
    src_a = regs_q[bus.seloutA];
    src_b = regs_q[bus.seloutB];
    if (bus.cnstA && bus.regwen && (bus.selwreg == bus.seloutA)) begin
      src_a = wr_merged;
    end
    if (bus.cnstB && bus.regwen && (bus.selwreg == bus.seloutB)) begin
      src_b = wr_merged;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.regwen) begin
      regs_d[bus.selwreg] = wr_merged;
    end
    outa_d = bus.enrregA ? src_a : outa_q;
    outb_d = bus.enrregB ? src_b : outb_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      outa_q <= '0;
      outb_q <= '0;
    end else begin
      regs_q <= regs_d;
      outa_q <= outa_d;
      outb_q <= outb_d;
    end
  end

  assign bus.outA = outa_q;
  assign bus.outB = outb_q;
endmodule

// File: tb/tb_reg_bank_16x64.sv
// tb/tb_reg_bank_16x64.sv - randomized self-checking bench for reg_bank_16x64
module tb_reg_bank_16x64;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  reg_bank_16x64_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_bank_16x64 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [63:0] mdl_regs [NREGS];
  logic [63:0] mdl_a;
  logic [63:0] mdl_b;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [1:0] mode);
    logic [63:0] mask;
    mask = {64{1'b1}};
`ifdef REG_BANK_WRITE_MASK_EN
    if (mode == 2'd1) mask = (64'd1 << 32) - 64'd1;
    else if (mode == 2'd2) mask = ~((64'd1 << 32) - 64'd1);
    else if (mode == 2'd3) mask = (64'd1 << 16) - 64'd1;
`else
    if (mode > 2'd3) mask = '0;
`endif
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) mdl_regs[i] = '0;
    mdl_a = '0;
    mdl_b = '0;
  endfunction

  task automatic set_idle();
    bus.regwen  = 1'b0;
    bus.inA     = '0;
    bus.selwreg = '0;
    bus.endwreg = 2'd0;
    bus.seloutA = '0;
    bus.seloutB = '0;
    bus.enrregA = 1'b0;
    bus.enrregB = 1'b0;
    bus.cnstA   = 1'b0;
    bus.cnstB   = 1'b0;
  endtask

  // One clock edge with the currently driven inputs; model advances, both outputs checked.
  task automatic cycle(input string tag);
    logic [63:0] nxt, sa, sb;
    int ws;
    ws  = int'(bus.selwreg);
    nxt = merge(mdl_regs[ws], bus.inA, bus.endwreg);
    sa  = (bus.cnstA && bus.regwen && ws == int'(bus.seloutA)) ? nxt : mdl_regs[bus.seloutA];
    sb  = (bus.cnstB && bus.regwen && ws == int'(bus.seloutB)) ? nxt : mdl_regs[bus.seloutB];
    if (bus.enrregA) mdl_a = sa;
    if (bus.enrregB) mdl_b = sb;
    if (bus.regwen) mdl_regs[ws] = nxt;
    @(posedge clock);
    #1;
    chk({tag, "_outA"}, bus.outA, mdl_a);
    chk({tag, "_outB"}, bus.outB, mdl_b);
  endtask

  task automatic write_reg(input int idx, input logic [63:0] val, input logic [1:0] mode);
    set_idle();
    bus.regwen  = 1'b1;
    bus.selwreg = idx[3:0];
    bus.inA     = val;
    bus.endwreg = mode;
    cycle("wr");
  endtask

  task automatic read_a(input int idx, input logic [63:0] exp, input string tag);
    set_idle();
    bus.seloutA = idx[3:0];
    bus.enrregA = 1'b1;
    cycle("rd");
    chk(tag, bus.outA, exp);
  endtask

  logic [63:0] held;
  logic [63:0] fill_base;

  initial begin
    set_idle();
    model_clear();
    #12;
    chk("reset_outA", bus.outA, 64'd0);
    chk("reset_outB", bus.outB, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Fill and read back through port B with bypass enabled
    fill_base = 64'hAB0075C156_00EB80;
    for (int i = 0; i < NREGS; i++) write_reg(i, fill_base + 64'(16 * (i + 1)), 2'd0);
    for (int i = 0; i < NREGS; i++) begin
      set_idle();
      bus.seloutB = 4'(i);
      bus.enrregB = 1'b1;
      bus.cnstB   = 1'b1;
      cycle("fill");
      chk("fill_readback", bus.outB, fill_base + 64'(16 * (i + 1)));
    end

    // Hold: outA frozen while its index moves, then reloads
    read_a(4, fill_base + 64'd80, "hold_load");
    held = bus.outA;
    for (int i = 0; i < 4; i++) begin
      set_idle();
      bus.seloutA = 4'(i + 9);
      cycle("hold");
      chk("hold_outA", bus.outA, held);
    end
    bus.enrregA = 1'b1;
    cycle("hold_release");
    chk("hold_reload", bus.outA, fill_base + 64'd16 * 64'd13);

    // Bypass versus old value on a same-index read/write
    set_idle();
    bus.regwen = 1'b1; bus.selwreg = 4'd5; bus.seloutB = 4'd5;
    bus.inA = 64'h1234; bus.enrregB = 1'b1; bus.cnstB = 1'b1;
    cycle("bypass_on");
    chk("bypass_on_val", bus.outB, 64'h1234);
    bus.inA = 64'h5678; bus.cnstB = 1'b0;
    cycle("bypass_off");
    chk("bypass_off_old", bus.outB, 64'h1234);
    read_a(5, 64'h5678, "bypass_after");

`ifdef REG_BANK_WRITE_MASK_EN
    write_reg(3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
    write_reg(3, 64'd0, 2'd1);
    read_a(3, 64'hFFFF_FFFF_0000_0000, "lane_low_half");
    write_reg(3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
    write_reg(3, 64'd0, 2'd3);
    read_a(3, 64'hFFFF_FFFF_FFFF_0000, "lane_low_qtr");
    write_reg(3, 64'd0, 2'd2);
    read_a(3, 64'h0000_0000_FFFF_0000, "lane_high_half");
`else
    write_reg(3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
    write_reg(3, 64'd0, 2'd1);
    read_a(3, 64'd0, "lane_ignored");
`endif

    // Dual read on the same edge
    set_idle();
    bus.seloutA = 4'd2; bus.seloutB = 4'd7; bus.enrregA = 1'b1; bus.enrregB = 1'b1;
    cycle("dual");
    chk("dual_outA", bus.outA, fill_base + 64'd48);
    chk("dual_outB", bus.outB, fill_base + 64'd128);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.regwen  = 1'($urandom_range(0, 1));
      bus.inA     = {$urandom, $urandom};
      bus.selwreg = 4'($urandom_range(0, 15));
      bus.endwreg = 2'($urandom_range(0, 3));
      bus.seloutA = ($urandom_range(0, 3) == 0) ? bus.selwreg : 4'($urandom_range(0, 15));
      bus.seloutB = ($urandom_range(0, 3) == 0) ? bus.selwreg : 4'($urandom_range(0, 15));
      bus.enrregA = 1'($urandom_range(0, 1));
      bus.enrregB = 1'($urandom_range(0, 1));
      bus.cnstA   = 1'($urandom_range(0, 1));
      bus.cnstB   = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    // Asynchronous reset mid-cycle, then every register must read zero
    set_idle();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_outA", bus.outA, 64'd0);
    chk("async_rst_outB", bus.outB, 64'd0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      set_idle();
      bus.seloutA = 4'(i); bus.seloutB = 4'(15 - i);
      bus.enrregA = 1'b1; bus.enrregB = 1'b1;
      cycle("post_rst");
      chk("post_rst_zero", bus.outA | bus.outB, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
